// File: rtl/mod_exp_engine.sv
// Modular exponentiation x^e mod m on a single bit-serial Montgomery multiplier.
// Mode 0 is left-to-right square-and-multiply; mode 1 is a constant-time Montgomery ladder.

module mont_mul_unit #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {MM_IDLE, MM_RUN, MM_FIX} mm_state_t;

    mm_state_t        state_q;
    logic [WIDTH-1:0] a_q, b_q, m_q, result_q;
    logic [WIDTH+1:0] s_q, s_add_b, s_add_m;
    logic [IW-1:0]    cnt_q;
    logic             done_q;

    // Partial sum stays below 2m, so two guard bits cover s + b + m.
    always_comb begin
        s_add_b = s_q + (a_q[0] ? {2'b00, b_q} : '0);
        s_add_m = s_add_b + (s_add_b[0] ? {2'b00, m_q} : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MM_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MM_IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        m_q     <= m_i;
                        s_q     <= '0;
                        cnt_q   <= IW'(WIDTH - 1);
                        state_q <= MM_RUN;
                    end
                end
                MM_RUN: begin
                    s_q <= s_add_m >> 1;
                    a_q <= a_q >> 1;
                    if (cnt_q == '0) begin
                        state_q <= MM_FIX;
                    end else begin
                        cnt_q <= cnt_q - IW'(1);
                    end
                end
                MM_FIX: begin
                    result_q <= (s_q >= {2'b00, m_q}) ? WIDTH'(s_q - {2'b00, m_q})
                                                      : s_q[WIDTH-1:0];
                    done_q   <= 1'b1;
                    state_q  <= MM_IDLE;
                end
                default: state_q <= MM_IDLE;
            endcase
        end
    end

    assign result_o = result_q;
    assign done_o   = done_q;
endmodule

module mod_exp_engine #(
    parameter int WIDTH = 512,
    parameter int CW    = $clog2(2*WIDTH+3)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0] in_m,
    input  logic [WIDTH-1:0] in_rmodm,
    input  logic [WIDTH-1:0] in_r2modm,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    mult_count
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        IDLE, LOAD, XT_MUL, SCAN, SQ_MUL, TEST, XM_MUL, NEXT,
        LAD_MUL0, LAD_MUL1, FIN_MUL, DONE
    } state_t;

    state_t           state_q;
    logic             mode_q;
    logic [WIDTH-1:0] x_q, e_q, m_q, r_q, r2_q;
    logic [WIDTH-1:0] a_q, b_q, xt_q, result_q;
    logic [IW-1:0]    i_q;
    logic [CW-1:0]    mult_count_q;
    logic             wait_q, done_q;

    logic             is_mul, mul_issue, mul_capture, bit_e;
    logic [WIDTH-1:0] mul_a, mul_b, mul_res;
    logic             mul_done;

    always_comb begin
        is_mul = (state_q == XT_MUL) || (state_q == SQ_MUL) || (state_q == XM_MUL) ||
                 (state_q == LAD_MUL0) || (state_q == LAD_MUL1) || (state_q == FIN_MUL);
        mul_issue   = is_mul && !wait_q;
        mul_capture = is_mul && wait_q && mul_done;
        bit_e       = e_q[i_q];
    end

    always_comb begin
        mul_a = a_q;
        mul_b = a_q;
        case (state_q)
            XT_MUL:   begin mul_a = x_q; mul_b = r2_q; end
            XM_MUL:   mul_b = xt_q;
            LAD_MUL0: mul_b = b_q;
            LAD_MUL1: begin
                mul_a = bit_e ? b_q : a_q;
                mul_b = bit_e ? b_q : a_q;
            end
            FIN_MUL:  mul_b = {{(WIDTH-1){1'b0}}, 1'b1};
            default:  ;
        endcase
    end

    mont_mul_unit #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst_n    (resetn),
        .start_i  (mul_issue),
        .a_i      (mul_a),
        .b_i      (mul_b),
        .m_i      (m_q),
        .result_o (mul_res),
        .done_o   (mul_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            x_q          <= '0;
            e_q          <= '0;
            m_q          <= '0;
            r_q          <= '0;
            r2_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            xt_q         <= '0;
            result_q     <= '0;
            i_q          <= '0;
            mult_count_q <= '0;
            wait_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            if (mul_issue) begin
                wait_q       <= 1'b1;
                mult_count_q <= mult_count_q + CW'(1);
            end
            if (mul_capture) begin
                wait_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        x_q     <= in_x;
                        e_q     <= in_e;
                        m_q     <= in_m;
                        r_q     <= in_rmodm;
                        r2_q    <= in_r2modm;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    a_q          <= r_q;
                    b_q          <= '0;
                    i_q          <= IW'(WIDTH - 1);
                    mult_count_q <= '0;
                    state_q      <= XT_MUL;
                end
                XT_MUL: begin
                    if (mul_capture) begin
                        xt_q <= mul_res;
                        if (mode_q) begin
                            b_q     <= mul_res;
                            state_q <= LAD_MUL0;
                        end else begin
                            state_q <= SCAN;
                        end
                    end
                end
                // Skip leading zeros; an all-zero exponent goes straight to the final conversion.
                SCAN: begin
                    if (bit_e)            state_q <= SQ_MUL;
                    else if (i_q != '0)   i_q <= i_q - IW'(1);
                    else                  state_q <= FIN_MUL;
                end
                SQ_MUL: begin
                    if (mul_capture) begin
                        a_q     <= mul_res;
                        state_q <= TEST;
                    end
                end
                TEST: state_q <= bit_e ? XM_MUL : NEXT;
                XM_MUL: begin
                    if (mul_capture) begin
                        a_q     <= mul_res;
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (i_q != '0) begin
                        i_q     <= i_q - IW'(1);
                        state_q <= SQ_MUL;
                    end else begin
                        state_q <= FIN_MUL;
                    end
                end
                LAD_MUL0: begin
                    if (mul_capture) begin
                        if (bit_e) a_q <= mul_res;
                        else       b_q <= mul_res;
                        state_q <= LAD_MUL1;
                    end
                end
                LAD_MUL1: begin
                    if (mul_capture) begin
                        if (bit_e) b_q <= mul_res;
                        else       a_q <= mul_res;
                        if (i_q == '0) begin
                            state_q <= FIN_MUL;
                        end else begin
                            i_q     <= i_q - IW'(1);
                            state_q <= LAD_MUL0;
                        end
                    end
                end
                FIN_MUL: begin
                    if (mul_capture) begin
                        result_q <= mul_res;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result     = result_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign mult_count = mult_count_q;
endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed bench for mod_exp_engine at WIDTH=16 with an arithmetic reference model.
module tb_mod_exp_engine;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [W-1:0]  in_x = '0, in_e = '0, in_m = '0, in_rmodm = '0, in_r2modm = '0;
    logic [W-1:0]  result;
    logic          busy, done;
    logic [5:0]    mult_count;

    int checks = 0;
    int passes = 0;

    logic [W-1:0]  exp_res = '0;
    int            exp_cnt = 0;
    bit            exp_valid = 1'b0;
    bit            done_seen = 1'b0;
    logic [W-1:0]  hold_res = '0;
    bit            prev_done = 1'b0;

    mod_exp_engine #(.WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .mode       (mode),
        .in_x       (in_x),
        .in_e       (in_e),
        .in_m       (in_m),
        .in_rmodm   (in_rmodm),
        .in_r2modm  (in_r2modm),
        .result     (result),
        .busy       (busy),
        .done       (done),
        .mult_count (mult_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    function automatic longint modexp(input longint x, input longint e, input longint m);
        longint r, b, k;
        r = 1 % m;
        b = x % m;
        k = e;
        while (k > 0) begin
            if (k[0]) r = (r * b) % m;
            b = (b * b) % m;
            k = k >> 1;
        end
        return r;
    endfunction

    function automatic int exp_count(input bit md, input longint e);
        int bl, pc;
        bl = 0;
        pc = 0;
        if (md) return 2*W + 2;
        for (int b = 0; b < W; b++) begin
            if (e[b]) begin
                pc++;
                bl = b + 1;
            end
        end
        return 2 + bl + pc;
    endfunction

    // Single compare process: completion values, done pulse width, spurious completions, result hold.
    always @(negedge clk) begin
        if (resetn) begin
            if (done) begin
                if (!exp_valid) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    chk("result", longint'(result), longint'(exp_res));
                    chk("mult_count", longint'(mult_count), longint'(exp_cnt));
                    chk("busy_at_done", longint'(busy), 1);
                    hold_res  = exp_res;
                    exp_valid = 1'b0;
                end
                done_seen = 1'b1;
                if (prev_done) chk("done_width", 2, 1);
            end else if (!busy) begin
                chk("result_hold", longint'(result), longint'(hold_res));
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic launch(input bit md, input logic [W-1:0] x, input logic [W-1:0] e,
                          input logic [W-1:0] m);
        longint r, r2;
        r  = 65536 % longint'(m);
        r2 = (r * r) % longint'(m);
        mode      = md;
        in_x      = x;
        in_e      = e;
        in_m      = m;
        in_rmodm  = W'(r);
        in_r2modm = W'(r2);
        exp_res   = W'(modexp(longint'(x), longint'(e), longint'(m)));
        exp_cnt   = exp_count(md, longint'(e));
        exp_valid = 1'b1;
        done_seen = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done_seen && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done_seen) begin
            chk({name, "_timeout"}, 0, 1);
            exp_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        // Pin the reference model against hand-computed values.
        chk("model_5_3_13", modexp(5, 3, 13), 8);
        chk("model_2_10_13", modexp(2, 10, 13), 10);
        chk("model_5_0_13", modexp(5, 0, 13), 1);
        chk("count_m0_e3", exp_count(1'b0, 3), 6);
        chk("count_m0_e10", exp_count(1'b0, 10), 8);
        chk("count_m0_e0", exp_count(1'b0, 0), 2);
        chk("count_m1", exp_count(1'b1, 3), 34);

        #20;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_result", longint'(result), 0);
        chk("rst_count", longint'(mult_count), 0);
        #2 resetn = 1'b1;
        @(negedge clk);

        launch(1'b0, 16'd5, 16'd3, 16'd13);
        wait_done("sqm_5_3");
        chk("lit_sqm_result", longint'(result), 8);
        chk("lit_sqm_count", longint'(mult_count), 6);

        launch(1'b1, 16'd5, 16'd3, 16'd13);
        wait_done("lad_5_3");
        chk("lit_lad_result", longint'(result), 8);
        chk("lit_lad_count", longint'(mult_count), 34);

        launch(1'b0, 16'd5, 16'd0, 16'd13);
        wait_done("sqm_e0");
        chk("lit_sqm_e0_count", longint'(mult_count), 2);
        launch(1'b1, 16'd5, 16'd0, 16'd13);
        wait_done("lad_e0");
        chk("lit_lad_e0_result", longint'(result), 1);

        launch(1'b0, 16'd1234, 16'hBEEF, 16'd65521);
        wait_done("sqm_big");
        launch(1'b1, 16'd1234, 16'hBEEF, 16'd65521);
        wait_done("lad_big");
        launch(1'b0, 16'd7, 16'h8000, 16'd65535);
        wait_done("sqm_msb");
        launch(1'b0, 16'd12, 16'd1, 16'd13);
        wait_done("sqm_e1");
        launch(1'b1, 16'd0, 16'd5, 16'd13);
        wait_done("lad_x0");

        // Start pulse while busy must be ignored.
        launch(1'b0, 16'd5, 16'd3, 16'd13);
        repeat (10) @(negedge clk);
        in_x  = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        chk("lit_busy_start_result", longint'(result), 8);
        repeat (5) @(negedge clk);
        chk("no_restart_busy", longint'(busy), 0);

        // Inputs changed right after start must not matter.
        launch(1'b1, 16'd5, 16'd3, 16'd13);
        @(posedge clk);
        #1;
        in_x = 16'd9;
        in_e = 16'd7;
        in_m = 16'd11;
        mode = 1'b0;
        wait_done("latched_inputs");

        // Abort during the first squaring.
        launch(1'b0, 16'd5, 16'd3, 16'd13);
        begin
            int n;
            n = 0;
            while (mult_count != 6'd2 && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("reach_sq_mul", longint'(mult_count), 2);
        end
        resetn    = 1'b0;
        exp_valid = 1'b0;
        hold_res  = '0;
        #1;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_result", longint'(result), 0);
        chk("abort_count", longint'(mult_count), 0);
        chk("abort_done", longint'(done), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        launch(1'b0, 16'd2, 16'd10, 16'd13);
        wait_done("after_abort");
        chk("lit_after_abort_result", longint'(result), 10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mod_exp_engine.md
MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 512, operand/modulus bit width (>=8).
REQ-002 SHALL have parameter CW, default $clog2(2*WIDTH+3), width of mult_count.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port mode  input  1  0 = left-to-right square-and-multiply, 1 = Montgomery ladder (constant-time).
REQ-007 SHALL have ports in_x, in_e, in_m, in_rmodm, in_r2modm  input  WIDTH each  base, exponent, odd modulus, R mod m, R^2 mod m (R = 2^WIDTH).
REQ-008 SHALL have port result  output  WIDTH  x^e mod m; held until next completion.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse on completion.
REQ-011 SHALL have port mult_count  output  CW  Montgomery multiplications issued in current/last operation.

Function
REQ-012 SHALL instantiate one team montgomery multiplier of width WIDTH (start pulse, in_a, in_b, in_m, result, done); exactly one multiplication in flight.
REQ-013 SHALL latch mode and all in_* operands on the clock edge where start=1 in IDLE; later input changes SHALL NOT affect the operation.
REQ-014 SHALL ignore start while busy=1.
REQ-015 SHALL use states IDLE, LOAD, XT_MUL, SCAN, SQ_MUL, TEST, XM_MUL, NEXT, LAD_MUL0, LAD_MUL1, FIN_MUL, DONE.
REQ-016 Each *_MUL state SHALL pulse multiplier start for exactly one cycle on entry, wait for multiplier done, capture its result, then transition; mult_count increments on each start pulse.
REQ-017 LOAD: A <= rmodm, B <= 0, bit index i <= WIDTH-1, mult_count <= 0; -> XT_MUL.
REQ-018 XT_MUL: Xt <= MontMul(x, r2modm); mode 0 -> SCAN; mode 1 -> B <= Xt, -> LAD_MUL0.
REQ-019 SCAN (mode 0): one bit per cycle; e[i]=1 -> SQ_MUL; e[i]=0 and i>0 -> i <= i-1; e[i]=0 and i=0 (e==0) -> FIN_MUL.
REQ-020 SQ_MUL: A <= MontMul(A,A) -> TEST; TEST: e[i]=1 -> XM_MUL else NEXT; XM_MUL: A <= MontMul(A,Xt) -> NEXT.
REQ-021 NEXT: i>0 -> i <= i-1, -> SQ_MUL; i=0 -> FIN_MUL.
REQ-022 Ladder (mode 1) SHALL process all WIDTH bits from WIDTH-1 to 0 regardless of leading zeros: e[i]=1: LAD_MUL0 A <= MontMul(A,B), LAD_MUL1 B <= MontMul(B,B); e[i]=0: LAD_MUL0 B <= MontMul(A,B), LAD_MUL1 A <= MontMul(A,A); after LAD_MUL1 i=0 -> FIN_MUL else i <= i-1, -> LAD_MUL0.
REQ-023 Ladder LAD_MUL0 SHALL use A and B values registered before that bit (no forwarding of same-bit result).
REQ-024 FIN_MUL: result <= MontMul(A, 1) -> DONE.
REQ-025 DONE: done=1 for one cycle, result valid from this cycle; -> IDLE unconditionally.
REQ-026 mult_count SHALL equal 2 + popcount-based count in mode 0 (1 + bitlen(e) + popcount(e) + 1) and exactly 2*WIDTH+2 in mode 1.
REQ-027 e=0 SHALL yield result = 1 mod m in both modes.
REQ-028 Counter i SHALL never wrap below 0; bit index i of CW-independent width $clog2(WIDTH).

Reset
REQ-029 resetn=0 SHALL asynchronously force state IDLE, result=0, busy=0, done=0, mult_count=0, internal A/B/Xt/i cleared, and hold the multiplier in reset.
REQ-030 Reset asserted mid-operation SHALL abort it; after release the block SHALL accept a new start with no residual effect.

Verification (WIDTH=16)
REQ-031 mode=0, x=5, e=3, m=13, rmodm=3, r2modm=9 -> result=8, done pulse 1 cycle, mult_count=6.
REQ-032 mode=1, same operands -> result=8, mult_count=34.
REQ-033 mode=0 and mode=1, e=0, x=5, m=13 -> result=1; mult_count=2 (mode 0), 34 (mode 1).
REQ-034 start re-asserted while busy with different x -> ignored; result of first operation (8) unchanged.
REQ-035 resetn pulsed low during SQ_MUL -> busy=0, result=0 immediately; new start (x=2, e=10, m=13) -> result=10.
REQ-036 in_x changed one cycle after start -> result still computed from latched x.
